// File: rtl/packet_assembler_pkg.sv
// Shared definitions for the packet framing path.
// - Default field and drop-counter widths.
// - FSM state codes for the word assembler.
// - Packet field bundle, also used by the downstream pass-through stage.
// - Framing-error classifier used by the assembler FSM.
package packet_assembler_pkg;

  localparam int PKT_WIDTH      = 16;
  localparam int DROP_CNT_WIDTH = 8;

  // Assembler states: which word of the frame is expected next.
  localparam logic [1:0] ST_HDR  = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  typedef struct packed {
    logic [PKT_WIDTH-1:0] header;
    logic [PKT_WIDTH-1:0] addr;
    logic [PKT_WIDTH-1:0] data;
  } packet_t;

  // A framing error is a non-sof word where a header is expected, or a
  // sof word arriving while a frame is only partially collected.
  function automatic logic framing_error(input logic [1:0] state, input logic sof);
    logic err;
    case (state)
      ST_HDR:  err = !sof;
      ST_ADDR: err = sof;
      ST_DATA: err = sof;
      default: err = 1'b0;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/packet_assembler_if.sv
// Bus bundle for packet_assembler.
// - io_in_*        : serial word stream (valid/ready, sof marks header word).
// - io_outPacket_* : assembled packet (valid/ready, header/addr/data).
// - io_dropCount   : saturating framing-error count.
// Modports: master = word producer / packet consumer side, slave = assembler.
interface packet_assembler_if
  import packet_assembler_pkg::*;
#(
  parameter int WIDTH     = PKT_WIDTH,
  parameter int CNT_WIDTH = DROP_CNT_WIDTH
);
  logic                 io_in_valid;
  logic                 io_in_ready;
  logic [WIDTH-1:0]     io_in_bits;
  logic                 io_in_sof;
  logic                 io_outPacket_valid;
  logic                 io_outPacket_ready;
  logic [WIDTH-1:0]     io_outPacket_header;
  logic [WIDTH-1:0]     io_outPacket_addr;
  logic [WIDTH-1:0]     io_outPacket_data;
  logic [CNT_WIDTH-1:0] io_dropCount;

  modport master (
    output io_in_valid, io_in_bits, io_in_sof, io_outPacket_ready,
    input  io_in_ready, io_outPacket_valid, io_outPacket_header,
           io_outPacket_addr, io_outPacket_data, io_dropCount
  );

  modport slave (
    input  io_in_valid, io_in_bits, io_in_sof, io_outPacket_ready,
    output io_in_ready, io_outPacket_valid, io_outPacket_header,
           io_outPacket_addr, io_outPacket_data, io_dropCount
  );
endinterface

// File: rtl/packet_assembler_out_slot.sv
// packet_out_slot: one-entry valid/ready holding register for a packet.
// Ports:
// - clock, reset  : clock, asynchronous active-low reset.
// - load_i, pkt_i : write a new packet (only issued when free_o is high).
// - ready_i       : downstream accepts the held packet.
// - valid_o, pkt_o: held packet, stable while valid_o && !ready_i.
// - free_o        : slot can take a packet this cycle (empty or draining).
module packet_out_slot #(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load_i,
  input  logic [3*WIDTH-1:0] pkt_i,
  input  logic               ready_i,
  output logic               valid_o,
  output logic [3*WIDTH-1:0] pkt_o,
  output logic               free_o
);
  logic               valid_q, valid_d;
  logic [3*WIDTH-1:0] pkt_q, pkt_d;

  // Next slot contents: a load wins over a drain, so load+drain keeps valid.
  always_comb begin
    valid_d = valid_q;
    pkt_d   = pkt_q;
    if (load_i) begin
      valid_d = 1'b1;
      pkt_d   = pkt_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Slot registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      pkt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pkt_q   <= pkt_d;
    end
  end

  assign free_o  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign pkt_o   = pkt_q;
endmodule

// File: rtl/packet_assembler.sv
// packet_assembler: collects header/addr/data words from a serial stream
// into one parallel packet.
// Ports:
// - clock, reset : clock, asynchronous active-low reset.
// - io (slave)   : word input stream, packet output, drop counter.
// Misframed words are counted (saturating) in io_dropCount. Backpressure
// from the packet output only reaches the input while the data word is due.
module packet_assembler
  import packet_assembler_pkg::*;
#(
  parameter int WIDTH     = PKT_WIDTH,
  parameter int CNT_WIDTH = DROP_CNT_WIDTH
) (
  input logic               clock,
  input logic               reset,
  packet_assembler_if.slave io
);
  logic [1:0]           state_q, state_d;
  logic [WIDTH-1:0]     hdr_q, hdr_d;
  logic [WIDTH-1:0]     addr_q, addr_d;
  logic [CNT_WIDTH-1:0] drop_q, drop_d;

  logic               in_ready_s;
  logic               accept_s;
  logic               err_s;
  logic               load_s;
  logic               slot_free_s;
  logic               slot_valid_s;
  logic [3*WIDTH-1:0] slot_pkt_s;

  // Input ready: only the data word waits for room in the output slot.
  // Ready never looks at io_in_sof, so a sof word also waits there.
  always_comb begin
    case (state_q)
      ST_HDR:  in_ready_s = 1'b1;
      ST_ADDR: in_ready_s = 1'b1;
      ST_DATA: in_ready_s = slot_free_s;
      default: in_ready_s = 1'b1;
    endcase
  end

  assign accept_s = io.io_in_valid && in_ready_s;
  assign err_s    = accept_s && framing_error(state_q, io.io_in_sof);

  // Frame FSM: a sof word always restarts the frame with itself as header.
  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    addr_d  = addr_q;
    load_s  = 1'b0;
    if (accept_s) begin
      case (state_q)
        ST_HDR: begin
          if (io.io_in_sof) begin
            hdr_d   = io.io_in_bits;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_HDR;
          end
        end
        ST_ADDR: begin
          if (io.io_in_sof) begin
            hdr_d   = io.io_in_bits;
            state_d = ST_ADDR;
          end else begin
            addr_d  = io.io_in_bits;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          if (io.io_in_sof) begin
            hdr_d   = io.io_in_bits;
            state_d = ST_ADDR;
          end else begin
            load_s  = 1'b1;
            state_d = ST_HDR;
          end
        end
        default: state_d = ST_HDR;
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // Saturating framing-error counter.
  always_comb begin
    if (err_s && (drop_q != {CNT_WIDTH{1'b1}})) begin
      drop_d = drop_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    end else begin
      drop_d = drop_q;
    end
  end

  // FSM, shadow and counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_HDR;
      hdr_q   <= '0;
      addr_q  <= '0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      addr_q  <= addr_d;
      drop_q  <= drop_d;
    end
  end

  packet_out_slot #(.WIDTH(WIDTH)) u_slot (
    .clock   (clock),
    .reset   (reset),
    .load_i  (load_s),
    .pkt_i   ({hdr_q, addr_q, io.io_in_bits}),
    .ready_i (io.io_outPacket_ready),
    .valid_o (slot_valid_s),
    .pkt_o   (slot_pkt_s),
    .free_o  (slot_free_s)
  );

  assign io.io_in_ready         = in_ready_s;
  assign io.io_outPacket_valid  = slot_valid_s;
  assign io.io_outPacket_header = slot_pkt_s[3*WIDTH-1:2*WIDTH];
  assign io.io_outPacket_addr   = slot_pkt_s[2*WIDTH-1:WIDTH];
  assign io.io_outPacket_data   = slot_pkt_s[WIDTH-1:0];
  assign io.io_dropCount        = drop_q;
endmodule
